// File: rtl/plic_source_arbiter_if.sv
// Claim/complete handshake between the PLIC MMIO register decode and the source arbiter.
interface plic_source_arbiter_if #(
   parameter int unsigned ID_W = 4
) ();
   logic            claim_req;
   logic            claim_valid;
   logic [ID_W-1:0] claim_id;
   logic            complete_req;
   logic [ID_W-1:0] complete_id;
   logic            complete_err;

   // Register decode side: issues claim reads and complete writes
   modport master (
      output claim_req,
      output complete_req,
      output complete_id,
      input  claim_valid,
      input  claim_id,
      input  complete_err
   );

   // Arbiter side: answers claims and flags ignored completes
   modport slave (
      input  claim_req,
      input  complete_req,
      input  complete_id,
      output claim_valid,
      output claim_id,
      output complete_err
   );
endinterface

// File: rtl/plic_source_arbiter.sv
// Interrupt gateway per source plus priority arbiter feeding a single hart interrupt line.
module plic_source_arbiter #(
   parameter int unsigned NSRC   = 8,
   parameter int unsigned PRIO_W = 3,
   parameter int unsigned ID_W   = 4
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic [NSRC-1:0]        irq_src,
   input  logic [NSRC-1:0]        src_enable,
   input  logic [NSRC*PRIO_W-1:0] src_prio,
   input  logic [PRIO_W-1:0]      threshold,
   plic_source_arbiter_if.slave   bus,
   output logic [NSRC-1:0]        pending,
   output logic                   irq_out
);

   typedef enum logic [1:0] {
      GW_IDLE     = 2'd0,
      GW_PENDING  = 2'd1,
      GW_INFLIGHT = 2'd2
   } gw_state_e;

   gw_state_e       gw_q [NSRC];
   gw_state_e       gw_d [NSRC];
   logic [NSRC-1:0] replay_q;
   logic [NSRC-1:0] replay_d;
   logic [NSRC-1:0] irq_prev;
   logic [NSRC-1:0] rise;
   logic [NSRC-1:0] eligible;
   logic [NSRC-1:0] claim_hit;
   logic [NSRC-1:0] complete_hit;

   logic [ID_W-1:0] best_id;
   logic [ID_W-1:0] best_id_d;
   logic [PRIO_W-1:0] best_prio_d;

   logic            claim_valid_q;
   logic [ID_W-1:0] claim_id_q;
   logic            complete_err_q;
   logic            claim_valid_d;
   logic [ID_W-1:0] claim_id_d;
   logic            complete_err_d;
   logic [NSRC-1:0] pending_d;
   logic            irq_d;

   assign rise             = irq_src & ~irq_prev;
   assign bus.claim_valid  = claim_valid_q;
   assign bus.claim_id     = claim_id_q;
   assign bus.complete_err = complete_err_q;

   // Eligibility on live inputs and max-priority pick, lowest index wins ties
   always_comb begin
      eligible    = '0;
      best_id_d   = '0;
      best_prio_d = '0;
      for (int i = 0; i < int'(NSRC); i++) begin
         eligible[i] = (gw_q[i] == GW_PENDING) && src_enable[i] &&
                       (src_prio[i*PRIO_W +: PRIO_W] > threshold);
         if (eligible[i] && (src_prio[i*PRIO_W +: PRIO_W] > best_prio_d)) begin
            best_prio_d = src_prio[i*PRIO_W +: PRIO_W];
            best_id_d   = ID_W'(i + 1);
         end
      end
   end

   // Decode which source a claim or complete targets; the registered winner must still be eligible
   always_comb begin
      claim_hit    = '0;
      complete_hit = '0;
      for (int i = 0; i < int'(NSRC); i++) begin
         claim_hit[i]    = bus.claim_req && eligible[i] && (best_id == ID_W'(i + 1));
         complete_hit[i] = bus.complete_req && (gw_q[i] == GW_INFLIGHT) &&
                           (bus.complete_id == ID_W'(i + 1));
      end
   end

   // Gateway state register
   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int i = 0; i < int'(NSRC); i++) begin
            gw_q[i] <= GW_IDLE;
         end
         replay_q <= '0;
         irq_prev <= '0;
      end else begin
         for (int i = 0; i < int'(NSRC); i++) begin
            gw_q[i] <= gw_d[i];
         end
         replay_q <= replay_d;
         irq_prev <= irq_src;
      end
   end

   // Gateway next state: edge capture, claim hand-off, completion with replay
   always_comb begin
      replay_d = replay_q;
      for (int i = 0; i < int'(NSRC); i++) begin
         gw_d[i] = gw_q[i];
         case (gw_q[i])
            GW_IDLE: begin
               if (rise[i]) gw_d[i] = GW_PENDING;
            end
            GW_PENDING: begin
               if (claim_hit[i]) gw_d[i] = GW_INFLIGHT;
            end
            GW_INFLIGHT: begin
               if (complete_hit[i]) begin
                  gw_d[i]     = (replay_q[i] || rise[i]) ? GW_PENDING : GW_IDLE;
                  replay_d[i] = 1'b0;
               end else if (rise[i]) begin
                  replay_d[i] = 1'b1;
               end
            end
            default: gw_d[i] = GW_IDLE;
         endcase
      end
   end

   // Next values of the registered outputs
   always_comb begin
      claim_valid_d  = bus.claim_req;
      claim_id_d     = (|claim_hit) ? best_id : '0;
      complete_err_d = bus.complete_req && !(|complete_hit);
      irq_d          = (best_id_d != '0);
      pending_d      = '0;
      for (int i = 0; i < int'(NSRC); i++) begin
         pending_d[i] = (gw_d[i] == GW_PENDING);
      end
   end

   // Output and arbitration result registers
   always_ff @(posedge clk) begin
      if (!rstn) begin
         best_id        <= '0;
         claim_valid_q  <= 1'b0;
         claim_id_q     <= '0;
         complete_err_q <= 1'b0;
         pending        <= '0;
         irq_out        <= 1'b0;
      end else begin
         best_id        <= best_id_d;
         claim_valid_q  <= claim_valid_d;
         claim_id_q     <= claim_id_d;
         complete_err_q <= complete_err_d;
         pending        <= pending_d;
         irq_out        <= irq_d;
      end
   end

endmodule

// File: tb/tb_plic_source_arbiter.sv
// Randomized + directed bench for the PLIC source arbiter with a queue-based scoreboard.
module tb_plic_source_arbiter;
   localparam int unsigned NSRC   = 8;
   localparam int unsigned PRIO_W = 3;
   localparam int unsigned ID_W   = 4;

   logic                   clk = 1'b0;
   logic                   rstn;
   logic [NSRC-1:0]        irq_src;
   logic [NSRC-1:0]        src_enable;
   logic [NSRC*PRIO_W-1:0] src_prio;
   logic [PRIO_W-1:0]      threshold;
   logic [NSRC-1:0]        pending;
   logic                   irq_out;

   plic_source_arbiter_if #(.ID_W(ID_W)) bus ();

   plic_source_arbiter #(.NSRC(NSRC), .PRIO_W(PRIO_W), .ID_W(ID_W)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .irq_src    (irq_src),
      .src_enable (src_enable),
      .src_prio   (src_prio),
      .threshold  (threshold),
      .bus        (bus),
      .pending    (pending),
      .irq_out    (irq_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit              cv;
      bit              cerr;
      logic [NSRC-1:0] pend;
      bit              irq;
   } stat_t;

   stat_t           stat_q [$];
   logic [ID_W-1:0] claim_q [$];
   int              n_checks = 0;
   int              n_fail   = 0;

   // Reference model: 0 idle, 1 waiting for service, 2 being serviced
   int              gw [NSRC];
   bit              rep [NSRC];
   logic [NSRC-1:0] prev_m;
   int              best_m;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int prio_of(input int i);
      return int'(src_prio[i*PRIO_W +: PRIO_W]);
   endfunction

   // Predict the effect of the upcoming clock edge from the inputs now applied
   task automatic model_step();
      stat_t s;
      int    nb, nbp, cid, ci, comp_idx;
      int    ng [NSRC];
      bit    r;
      s.cv = 0; s.cerr = 0; s.pend = '0; s.irq = 0;
      if (rstn !== 1'b1) begin
         for (int i = 0; i < int'(NSRC); i++) begin
            gw[i] = 0; rep[i] = 0;
         end
         prev_m = '0;
         best_m = 0;
         stat_q.push_back(s);
         return;
      end
      nb = 0; nbp = 0;
      for (int i = 0; i < int'(NSRC); i++) begin
         if (gw[i] == 1 && src_enable[i] && prio_of(i) > int'(threshold) && prio_of(i) > nbp) begin
            nb = i + 1; nbp = prio_of(i);
         end
      end
      cid = 0;
      if (bus.claim_req) begin
         s.cv = 1;
         if (best_m != 0) begin
            if (gw[best_m-1] == 1 && src_enable[best_m-1] && prio_of(best_m-1) > int'(threshold))
               cid = best_m;
         end
         claim_q.push_back(ID_W'(cid));
      end
      comp_idx = -1;
      if (bus.complete_req) begin
         ci = int'(bus.complete_id);
         if (ci >= 1 && ci <= int'(NSRC) && gw[(ci >= 1) ? ci-1 : 0] == 2) comp_idx = ci - 1;
         else s.cerr = 1;
      end
      for (int i = 0; i < int'(NSRC); i++) begin
         r = irq_src[i] && !prev_m[i];
         ng[i] = gw[i];
         if (gw[i] == 0) begin
            if (r) ng[i] = 1;
         end else if (gw[i] == 1) begin
            if (cid == i + 1) ng[i] = 2;
         end else begin
            if (i == comp_idx) begin
               ng[i] = (rep[i] || r) ? 1 : 0;
               rep[i] = 0;
            end else if (r) begin
               rep[i] = 1;
            end
         end
      end
      for (int i = 0; i < int'(NSRC); i++) begin
         gw[i] = ng[i];
         s.pend[i] = (ng[i] == 1);
      end
      prev_m = irq_src;
      best_m = nb;
      s.irq  = (nb != 0);
      stat_q.push_back(s);
   endtask

   // One clock: record expectations, let the edge pass, drop the request pulses
   task automatic tick();
      model_step();
      @(negedge clk);
      bus.claim_req    = 1'b0;
      bus.complete_req = 1'b0;
   endtask

   // Monitor: compare DUT outputs against queued expectations just after each edge
   initial begin
      stat_t e;
      forever begin
         @(posedge clk);
         #1;
         if (stat_q.size() > 0) begin
            e = stat_q.pop_front();
            check("claim_valid", 32'(bus.claim_valid), 32'(e.cv));
            check("complete_err", 32'(bus.complete_err), 32'(e.cerr));
            check("pending", 32'(pending), 32'(e.pend));
            check("irq_out", 32'(irq_out), 32'(e.irq));
            if (bus.claim_valid === 1'b1) begin
               if (claim_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL claim_id: unexpected claim response id 0x%0h at %0t", bus.claim_id, $time);
               end else begin
                  check("claim_id", 32'(bus.claim_id), 32'(claim_q.pop_front()));
               end
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, time %0t, required earlier end", $time);
      $fatal(1);
   end

   initial begin
      int k;
      rstn = 1'b0; irq_src = '0; src_enable = '0; src_prio = '0; threshold = '0;
      bus.claim_req = 1'b0; bus.complete_req = 1'b0; bus.complete_id = '0;
      @(negedge clk);
      tick(); tick();
      check("reset_pending", 32'(pending), 32'h0);
      check("reset_irq", 32'(irq_out), 32'h0);
      rstn = 1'b1;

      // Two equal-priority sources: lowest index claimed first
      src_enable = '1; src_prio[2*PRIO_W +: PRIO_W] = 3'd5; src_prio[5*PRIO_W +: PRIO_W] = 3'd5;
      threshold = 3'd2; irq_src = 8'h24;
      tick();
      check("t1_pending", 32'(pending), 32'h24);
      check("t1_irq_early", 32'(irq_out), 32'h0);
      irq_src = '0; tick();
      check("t1_irq", 32'(irq_out), 32'h1);
      bus.claim_req = 1'b1; tick();
      check("t1_claim3", 32'(bus.claim_id), 32'h3);
      tick();
      bus.claim_req = 1'b1; tick();
      check("t1_claim6", 32'(bus.claim_id), 32'h6);
      tick();
      check("t1_irq_off", 32'(irq_out), 32'h0);
      bus.complete_req = 1'b1; bus.complete_id = 4'd3; tick();
      bus.complete_req = 1'b1; bus.complete_id = 4'd6; tick();

      // Priority equal to threshold never interrupts
      src_prio[0 +: PRIO_W] = 3'd2; irq_src = 8'h01; tick();
      irq_src = '0; tick(); tick();
      check("t2_pending", 32'(pending), 32'h01);
      check("t2_irq_blocked", 32'(irq_out), 32'h0);
      threshold = 3'd1; tick();
      check("t2_irq", 32'(irq_out), 32'h1);
      bus.claim_req = 1'b1; tick();
      check("t2_claim1", 32'(bus.claim_id), 32'h1);
      bus.complete_req = 1'b1; bus.complete_id = 4'd1; tick();

      // Edge during service is replayed at completion
      src_prio[4*PRIO_W +: PRIO_W] = 3'd4; irq_src = 8'h10; tick();
      irq_src = '0; tick();
      bus.claim_req = 1'b1; tick();
      check("t3_claim5", 32'(bus.claim_id), 32'h5);
      irq_src = 8'h10; tick();
      irq_src = '0; tick();
      check("t3_inflight", 32'(pending), 32'h0);
      bus.complete_req = 1'b1; bus.complete_id = 4'd5; tick();
      check("t3_replay", 32'(pending), 32'h10);
      tick();
      check("t3_irq", 32'(irq_out), 32'h1);
      bus.claim_req = 1'b1; tick(); tick();
      bus.complete_req = 1'b1; bus.complete_id = 4'd5; tick();

      // Out-of-range and non-inflight completes are rejected
      bus.complete_req = 1'b1; bus.complete_id = 4'd0; tick();
      check("t4_err_id0", 32'(bus.complete_err), 32'h1);
      bus.complete_req = 1'b1; bus.complete_id = 4'd9; tick();
      check("t4_err_id9", 32'(bus.complete_err), 32'h1);
      bus.complete_req = 1'b1; bus.complete_id = 4'd3; tick();
      check("t4_err_idle", 32'(bus.complete_err), 32'h1);
      check("t4_pending", 32'(pending), 32'h0);

      // Winner disabled in the claim cycle returns ID 0 and stays pending
      src_prio[1*PRIO_W +: PRIO_W] = 3'd3; irq_src = 8'h02; tick();
      irq_src = '0; tick();
      src_enable[1] = 1'b0; bus.claim_req = 1'b1; tick();
      check("t5_claim_valid", 32'(bus.claim_valid), 32'h1);
      check("t5_claim0", 32'(bus.claim_id), 32'h0);
      check("t5_pending", 32'(pending), 32'h02);
      src_enable = '1; tick();
      bus.claim_req = 1'b1; tick();
      check("t5_claim2", 32'(bus.claim_id), 32'h2);
      bus.complete_req = 1'b1; bus.complete_id = 4'd2; tick();

      // Reset clears outstanding claims and pending sources
      src_prio[3*PRIO_W +: PRIO_W] = 3'd6; src_prio[6*PRIO_W +: PRIO_W] = 3'd2;
      irq_src = 8'h08; tick();
      irq_src = '0; tick();
      bus.claim_req = 1'b1; tick();
      check("t6_claim4", 32'(bus.claim_id), 32'h4);
      irq_src = 8'h40; tick();
      irq_src = '0; tick();
      check("t6_pending", 32'(pending), 32'h40);
      rstn = 1'b0; tick();
      rstn = 1'b1;
      check("t6_rst_pending", 32'(pending), 32'h0);
      check("t6_rst_irq", 32'(irq_out), 32'h0);
      bus.complete_req = 1'b1; bus.complete_id = 4'd4; tick();
      check("t6_err", 32'(bus.complete_err), 32'h1);

      // Random traffic against the model
      for (int c = 0; c < 3000; c++) begin
         irq_src = NSRC'($urandom) & NSRC'($urandom) & NSRC'($urandom);
         if ($urandom_range(0, 15) == 0) src_enable = NSRC'($urandom) | NSRC'($urandom);
         if ($urandom_range(0, 31) == 0) src_prio = (NSRC*PRIO_W)'($urandom);
         if ($urandom_range(0, 31) == 0) threshold = PRIO_W'($urandom_range(0, 3));
         bus.claim_req    = ($urandom_range(0, 3) == 0);
         bus.complete_req = ($urandom_range(0, 2) == 0);
         k = int'($urandom_range(0, NSRC - 1));
         if (gw[k] == 2 && $urandom_range(0, 3) != 0) bus.complete_id = ID_W'(k + 1);
         else bus.complete_id = ID_W'($urandom_range(0, 10));
         rstn = ($urandom_range(0, 299) != 0);
         tick();
      end

      rstn = 1'b1; irq_src = '0;
      tick(); tick(); tick();
      check("claim_q_drained", 32'(claim_q.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
